// File: rtl/tile_xfer_ctrl.sv
// Tile transfer sequencer: reads one tile over Avalon, runs the datapath, writes the result back.
// Optional watchdog enabled by defining TILE_XFER_TIMEOUT_EN.
module tile_xfer_ctrl #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 128,
   parameter int BEATS  = 8
) (
   input  logic                    iCLK,
   input  logic                    iRST_n,
   input  logic                    local_init_done,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       src_addr,
   input  logic [ADDR_W-1:0]       dst_addr,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [BEATS*DATA_W-1:0] tile_out,
   output logic                    calc_start,
   input  logic                    calc_done,
   input  logic [BEATS*DATA_W-1:0] result_in,
   input  logic                    avl_waitrequest_n,
   output logic [ADDR_W-1:0]       avl_address,
   output logic                    avl_read,
   output logic                    avl_write,
   output logic [DATA_W-1:0]       avl_writedata,
   input  logic                    avl_readdatavalid,
   input  logic [DATA_W-1:0]       avl_readdata,
   output logic                    avl_burstbegin
);
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, DONE} state_t;

   state_t                  state, state_nxt;
   logic [BW-1:0]           beat, beat_nxt;
   logic [ADDR_W-1:0]       src_q, dst_q, src_nxt, dst_nxt, addr_nxt;
   logic [BEATS*DATA_W-1:0] tile_buf, buf_nxt;
   logic [DATA_W-1:0]       wdata_nxt;
   logic                    rd_nxt, wr_nxt, busy_nxt, done_nxt, err_nxt, cs_nxt;
   logic                    last_beat;
   logic                    timeout;

   assign last_beat      = (beat == BW'(BEATS - 1));
   assign tile_out       = tile_buf;
   assign avl_burstbegin = avl_read | avl_write;

`ifdef TILE_XFER_TIMEOUT_EN
   logic [9:0] wdog;
   logic       in_xfer, progress;

   always_comb begin
      in_xfer  = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
      progress = (((state == RD_REQ) || (state == WR_REQ)) && avl_waitrequest_n)
               || ((state == RD_WAIT) && avl_readdatavalid);
   end

   // Watchdog restarts on every accept or returned beat.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n)
         wdog <= '0;
      else if (!in_xfer || progress)
         wdog <= '0;
      else
         wdog <= wdog + 10'd1;
   end

   assign timeout = in_xfer && !progress && (wdog == 10'h3FF);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      src_nxt   = src_q;
      dst_nxt   = dst_q;
      buf_nxt   = tile_buf;
      rd_nxt    = avl_read;
      wr_nxt    = avl_write;
      addr_nxt  = avl_address;
      wdata_nxt = avl_writedata;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = error;
      cs_nxt    = 1'b0;
      unique case (state)
         IDLE: if (start && local_init_done) begin
            src_nxt   = src_addr;
            dst_nxt   = dst_addr;
            beat_nxt  = '0;
            err_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            rd_nxt    = 1'b1;
            addr_nxt  = src_addr;
            state_nxt = RD_REQ;
         end
         RD_REQ: if (avl_waitrequest_n) begin
            rd_nxt    = 1'b0;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: if (avl_readdatavalid) begin
            buf_nxt[int'(beat)*DATA_W +: DATA_W] = avl_readdata;
            if (last_beat) begin
               beat_nxt  = '0;
               cs_nxt    = 1'b1;
               state_nxt = CALC;
            end else begin
               beat_nxt  = beat + 1'b1;
               rd_nxt    = 1'b1;
               addr_nxt  = src_q + ADDR_W'(beat) + ADDR_W'(1);
               state_nxt = RD_REQ;
            end
         end
         CALC: if (calc_done) begin
            buf_nxt   = result_in;
            wr_nxt    = 1'b1;
            addr_nxt  = dst_q;
            wdata_nxt = result_in[DATA_W-1:0];
            state_nxt = WR_REQ;
         end
         // Next beat is presented in the same edge as the accept, so writes run back-to-back.
         WR_REQ: if (avl_waitrequest_n) begin
            if (last_beat) begin
               wr_nxt    = 1'b0;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               beat_nxt  = '0;
               state_nxt = DONE;
            end else begin
               beat_nxt  = beat + 1'b1;
               addr_nxt  = dst_q + ADDR_W'(beat) + ADDR_W'(1);
               wdata_nxt = tile_buf[(int'(beat) + 1)*DATA_W +: DATA_W];
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (timeout) begin
         rd_nxt    = 1'b0;
         wr_nxt    = 1'b0;
         done_nxt  = 1'b1;
         busy_nxt  = 1'b0;
         err_nxt   = 1'b1;
         state_nxt = DONE;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state         <= IDLE;
         beat          <= '0;
         src_q         <= '0;
         dst_q         <= '0;
         tile_buf      <= '0;
         avl_read      <= 1'b0;
         avl_write     <= 1'b0;
         avl_address   <= '0;
         avl_writedata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         calc_start    <= 1'b0;
      end else begin
         state         <= state_nxt;
         beat          <= beat_nxt;
         src_q         <= src_nxt;
         dst_q         <= dst_nxt;
         tile_buf      <= buf_nxt;
         avl_read      <= rd_nxt;
         avl_write     <= wr_nxt;
         avl_address   <= addr_nxt;
         avl_writedata <= wdata_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         error         <= err_nxt;
         calc_start    <= cs_nxt;
      end
   end
endmodule

// File: tb/tb_tile_xfer_ctrl.sv
// Scoreboard bench for tile_xfer_ctrl: Avalon slave model, datapath model, expectation queues.
module tb_tile_xfer_ctrl;
   logic           iCLK = 1'b0;
   logic           iRST_n;
   logic           local_init_done;
   logic           start;
   logic [25:0]    src_addr, dst_addr;
   logic           busy, done, error, calc_start, calc_done;
   logic [1023:0]  tile_out, result_in;
   logic           avl_waitrequest_n, avl_read, avl_write, avl_readdatavalid, avl_burstbegin;
   logic [25:0]    avl_address;
   logic [127:0]   avl_writedata, avl_readdata;

   tile_xfer_ctrl dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .busy(busy), .done(done), .error(error),
      .tile_out(tile_out), .calc_start(calc_start), .calc_done(calc_done), .result_in(result_in),
      .avl_waitrequest_n(avl_waitrequest_n), .avl_address(avl_address), .avl_read(avl_read),
      .avl_write(avl_write), .avl_writedata(avl_writedata), .avl_readdatavalid(avl_readdatavalid),
      .avl_readdata(avl_readdata), .avl_burstbegin(avl_burstbegin)
   );

   always #5 iCLK = ~iCLK;

   logic [25:0]   exp_rd[$], exp_wa[$];
   logic [127:0]  exp_wd[$], rdv_d[$];
   logic [1023:0] exp_tile[$];
   int            rdv_t[$];
   int rd_acc = 0, wr_acc = 0, rd_stall_at = -1, wr_stall_at = -1;
   int rd_stall_cnt = 0, wr_stall_cnt = 0;
   int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, cs_cnt = 0, calc_dn = 0;
   bit drop_rdv = 1'b0;
   logic [1023:0] tile_hold;
   int n_chk = 0, n_err = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] memdata(input logic [25:0] a);
      return {6'h11, a, 6'h22, a, 6'h33, a, 6'h2A, a};
   endfunction

   function automatic logic [127:0] key(input int i);
      logic [7:0] b;
      b = 8'(i * 37 + 1);
      return {16{b}};
   endfunction

   function automatic logic [1023:0] keymask();
      logic [1023:0] m;
      for (int i = 0; i < 8; i++) m[i*128 +: 128] = key(i);
      return m;
   endfunction

   // Avalon slave: stall injection, scoreboard on every presented command, read latency 5.
   initial begin
      avl_waitrequest_n = 1'b1; avl_readdatavalid = 1'b0; avl_readdata = '0;
      forever begin
         @(negedge iCLK);
         avl_readdatavalid = 1'b0;
         avl_waitrequest_n = 1'b1;
         if (!iRST_n) begin
            rdv_d.delete(); rdv_t.delete();
            continue;
         end
         if (rdv_t.size() > 0 && rdv_t[0] == cyc) begin
            avl_readdatavalid = 1'b1;
            avl_readdata = rdv_d.pop_front();
            void'(rdv_t.pop_front());
         end
         if (avl_read) begin
            if (exp_rd.size() == 0) chk("rd_extra", avl_read, 0);
            else begin
               chk("rd_addr", avl_address, exp_rd[0]);
               chk("rd_burst", avl_burstbegin, 1);
               if (rd_acc == rd_stall_at && rd_stall_cnt < 4) begin
                  avl_waitrequest_n = 1'b0; rd_stall_cnt++;
               end else begin
                  void'(exp_rd.pop_front()); rd_acc++; rd_stall_cnt = 0; acc_cyc = cyc;
                  if (!drop_rdv) begin
                     rdv_d.push_back(memdata(avl_address)); rdv_t.push_back(cyc + 5);
                  end
               end
            end
         end
         if (avl_write) begin
            if (exp_wa.size() == 0) chk("wr_extra", avl_write, 0);
            else begin
               chk("wr_addr", avl_address, exp_wa[0]);
               chk("wr_data", avl_writedata, exp_wd[0]);
               if (wr_acc == wr_stall_at && wr_stall_cnt < 4) begin
                  avl_waitrequest_n = 1'b0; wr_stall_cnt++;
               end else begin
                  void'(exp_wa.pop_front()); void'(exp_wd.pop_front()); wr_acc++; wr_stall_cnt = 0;
               end
            end
         end
      end
   end

   // Datapath model: result = tile ^ per-beat key, 3 cycles after calc_start.
   initial begin
      calc_done = 1'b0; result_in = '0;
      forever begin
         @(negedge iCLK);
         calc_done = 1'b0;
         if (!iRST_n) begin calc_dn = 0; continue; end
         if (calc_start) begin
            cs_cnt++;
            if (exp_tile.size() > 0) chk("tile", tile_out, exp_tile.pop_front());
            tile_hold = tile_out;
            calc_dn = 3;
         end else if (calc_dn > 0) begin
            calc_dn--;
            if (calc_dn == 0) begin
               chk("tile_hold", tile_out, tile_hold);
               calc_done = 1'b1;
               result_in = tile_out ^ keymask();
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge iCLK);
         if (iRST_n && done) begin
            done_cnt++; done_cyc = cyc;
            chk("done_busy", busy, 0);
         end
      end
   end

   task automatic push_exp(input logic [25:0] s, input logic [25:0] d);
      logic [1023:0] t;
      for (int i = 0; i < 8; i++) begin
         exp_rd.push_back(s + 26'(i));
         exp_wa.push_back(d + 26'(i));
         exp_wd.push_back(memdata(s + 26'(i)) ^ key(i));
         t[i*128 +: 128] = memdata(s + 26'(i));
      end
      exp_tile.push_back(t);
   endtask

   task automatic pulse_start(input logic [25:0] s, input logic [25:0] d);
      src_addr = s; dst_addr = d; start = 1'b1;
      @(negedge iCLK);
      start = 1'b0; src_addr = '0; dst_addr = '0;
   endtask

   task automatic run_cmd(input logic [25:0] s, input logic [25:0] d, input int rs, input int ws, input bit disturb);
      int d0, c0, n;
      push_exp(s, d);
      rd_stall_at = (rs < 0) ? -1 : rd_acc + rs;
      wr_stall_at = (ws < 0) ? -1 : wr_acc + ws;
      d0 = done_cnt; c0 = cs_cnt;
      pulse_start(s, d);
      chk("busy_set", busy, 1);
      if (disturb) begin
         repeat (10) @(negedge iCLK);
         pulse_start(26'h3333, 26'h3444);
         local_init_done = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 3000) begin @(negedge iCLK); n++; end
      chk("done_seen", (done_cnt != d0), 1);
      repeat (3) @(negedge iCLK);
      chk("done_once", done_cnt - d0, 1);
      chk("cs_once", cs_cnt - c0, 1);
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
      chk("busy_idle", busy, 0);
      chk("err_clr", error, 0);
      local_init_done = 1'b1;
      rd_stall_at = -1; wr_stall_at = -1;
   endtask

   initial begin
      int n, d0;
      iRST_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; local_init_done = 1'b1;
      repeat (3) @(negedge iCLK);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read", avl_read, 0);
      chk("rst_write", avl_write, 0);
      chk("rst_addr", avl_address, 0);
      chk("rst_tile", tile_out, 0);
      iRST_n = 1'b1;
      @(negedge iCLK);

      run_cmd(26'h100, 26'h200, -1, -1, 1'b0);
      run_cmd(26'h1000, 26'h2000, 3, 6, 1'b0);
      run_cmd(26'h3FFFFFE, 26'h300, -1, -1, 1'b0);

      local_init_done = 1'b0;
      pulse_start(26'h700, 26'h800);
      repeat (5) @(negedge iCLK);
      chk("noinit_busy", busy, 0);
      chk("noinit_read", avl_read, 0);
      local_init_done = 1'b1;

      run_cmd(26'h40, 26'h80, -1, -1, 1'b1);

      // Reset asserted in the middle of the write phase.
      push_exp(26'h900, 26'hA00);
      pulse_start(26'h900, 26'hA00);
      n = 0;
      while (!avl_write && n < 500) begin @(negedge iCLK); n++; end
      chk("wr_reached", avl_write, 1);
      repeat (2) @(negedge iCLK);
      d0 = done_cnt;
      #2 iRST_n = 1'b0;
      #1;
      chk("arst_write", avl_write, 0);
      chk("arst_read", avl_read, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", avl_address, 0);
      chk("arst_wdata", avl_writedata, 0);
      chk("arst_tile", tile_out, 0);
      @(negedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b1;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_tile.delete();
      repeat (20) @(negedge iCLK);
      chk("arst_nodone", done_cnt - d0, 0);
      chk("arst_idle", busy, 0);

      run_cmd(26'h100, 26'h200, -1, -1, 1'b0);

`ifdef TILE_XFER_TIMEOUT_EN
      drop_rdv = 1'b1;
      exp_rd.push_back(26'h500);
      d0 = done_cnt;
      pulse_start(26'h500, 26'h600);
      n = 0;
      while (done_cnt == d0 && n < 1300) begin @(negedge iCLK); n++; end
      chk("to_done", (done_cnt != d0), 1);
      chk("to_lat", done_cyc - acc_cyc, 1025);
      chk("to_err", error, 1);
      repeat (3) @(negedge iCLK);
      chk("to_err_hold", error, 1);
      drop_rdv = 1'b0;
      exp_rd.delete();
      run_cmd(26'h120, 26'h220, -1, -1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
